// File: rtl/mult_serial_ctrl.sv
// mult_serial_ctrl: serial-pad sequencer for a parallel WIDTHxWIDTH multiplier; optional operand parity via MULT_CTRL_PARITY_EN
module mult_serial_ctrl #(
    parameter int WIDTH   = 16,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               a_pad,
    input  logic               b_pad,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               p0,
    output logic               p1,
    output logic               p_valid,
    output logic               busy,
    output logic               done,
    output logic               par_err
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, UNLOAD, DONE} state_t;
    localparam int CW = $clog2((WIDTH > MUL_LAT ? WIDTH : MUL_LAT) + 2);
`ifdef MULT_CTRL_PARITY_EN
    localparam int LOAD_LEN = WIDTH + 1;
`else
    localparam int LOAD_LEN = WIDTH;
`endif
    state_t state, state_next;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] prod;
    logic bad;
    logic shift_in;
`ifdef MULT_CTRL_PARITY_EN
    assign bad = (a_pad != ^op_a) || (b_pad != ^op_b);
`else
    assign bad = 1'b0;
    assign par_err = 1'b0;
`endif
    assign shift_in = (state == LOAD) && (cnt < CW'(WIDTH));
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    // next-state and decoded outputs; the parity slot is the extra last LOAD cycle
    always_comb begin
        state_next = state;
        busy       = state != IDLE;
        done       = state == DONE;
        p_valid    = state == UNLOAD;
        p0         = (state == UNLOAD) & prod[0];
        p1         = (state == UNLOAD) & prod[WIDTH];
        case (state)
            IDLE:    state_next = start ? LOAD : IDLE;
            LOAD:    state_next = (cnt == CW'(LOAD_LEN - 1)) ? (bad ? DONE : WAIT) : LOAD;
            WAIT:    state_next = (cnt == CW'(MUL_LAT - 1)) ? UNLOAD : WAIT;
            UNLOAD:  state_next = (cnt == CW'(WIDTH - 1)) ? DONE : UNLOAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    // shared phase counter, operand shifters and product shifter (both halves shift toward bit 0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            op_a <= '0;
            op_b <= '0;
            prod <= '0;
        end else begin
            cnt <= (state_next != state) ? '0 : cnt + CW'(1);
            if (shift_in) begin
                op_a <= {a_pad, op_a[WIDTH-1:1]};
                op_b <= {b_pad, op_b[WIDTH-1:1]};
            end
            if (state == WAIT && state_next == UNLOAD) prod <= mul_p;
            else if (state == UNLOAD) prod <= {1'b0, prod[2*WIDTH-1:WIDTH+1], 1'b0, prod[WIDTH-1:1]};
        end
    end
`ifdef MULT_CTRL_PARITY_EN
    // sticky parity error, cleared by the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 par_err <= 1'b0;
        else if (state == IDLE && start)         par_err <= 1'b0;
        else if (state == LOAD && state_next == DONE) par_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_mult_serial_ctrl.sv
// tb_mult_serial_ctrl: directed and randomized self-checking bench for mult_serial_ctrl at MUL_LAT 2, 1 and 15
module tb_mult_serial_ctrl;
    localparam int W = 16;
`ifdef MULT_CTRL_PARITY_EN
    localparam int LL = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int LL = W;
    localparam bit PAR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, start, a_pad, b_pad;
    logic [2:0][W-1:0] oa, ob;
    logic [2:0][2*W-1:0] mp;
    logic [2:0] pp0, pp1, pv, bz, dn, pe;
    int cyc, nchk, nfail;
    int nv [3], fv [3], dcnt [3], dcyc [3], bcnt [3];
    logic [W-1:0] s0 [3], s1 [3];
    bit rec;

    function automatic int lat(input int j);
        return j == 0 ? 2 : (j == 1 ? 1 : 15);
    endfunction

    for (genvar j = 0; j < 3; j++) begin : g
        assign mp[j] = {{W{1'b0}}, oa[j]} * {{W{1'b0}}, ob[j]};
        mult_serial_ctrl #(.WIDTH(W), .MUL_LAT(j == 0 ? 2 : (j == 1 ? 1 : 15))) u_dut (
            .clk(clk), .rst(rst), .start(start), .a_pad(a_pad), .b_pad(b_pad),
            .op_a(oa[j]), .op_b(ob[j]), .mul_p(mp[j]),
            .p0(pp0[j]), .p1(pp1[j]), .p_valid(pv[j]), .busy(bz[j]), .done(dn[j]), .par_err(pe[j])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (!rec) begin
                nv[j] <= 0; fv[j] <= 0; dcnt[j] <= 0; dcyc[j] <= 0; bcnt[j] <= 0;
                s0[j] <= '0; s1[j] <= '0;
            end else begin
                if (pv[j]) begin
                    if (nv[j] == 0) fv[j] <= cyc;
                    if (nv[j] < W) begin
                        s0[j][nv[j]] <= pp0[j];
                        s1[j][nv[j]] <= pp1[j];
                    end
                    nv[j] <= nv[j] + 1;
                end
                if (dn[j]) begin
                    dcnt[j] <= dcnt[j] + 1;
                    dcyc[j] <= cyc;
                end
                if (bz[j]) bcnt[j] <= bcnt[j] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic pa, input logic pb);
        logic [2*W-1:0] e;
        logic good;
        int t0;
        e = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        good = !PAR || (pa == ^a && pb == ^b);
        @(posedge clk) #1;
        rec = 1; t0 = cyc; start = 1;
        @(posedge clk) #1;
        start = 0;
        chk("par_err_cleared_on_start", {61'd0, pe}, 0);
        for (int i = 0; i < LL; i++) begin
            a_pad = i < W ? a[i] : pa;
            b_pad = i < W ? b[i] : pb;
            @(posedge clk) #1;
        end
        a_pad = 0; b_pad = 0;
        repeat (40) @(posedge clk);
        #1 rec = 0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("done_count[%0d]", j), dcnt[j], 1);
            chk($sformatf("done_cycle[%0d]", j), dcyc[j] - t0, good ? LL + lat(j) + W + 1 : LL + 1);
            chk($sformatf("busy_cycles[%0d]", j), bcnt[j], good ? LL + lat(j) + W + 1 : LL + 1);
            chk($sformatf("valid_cycles[%0d]", j), nv[j], good ? W : 0);
            chk($sformatf("par_err[%0d]", j), pe[j], !good);
            if (good) begin
                chk($sformatf("first_valid[%0d]", j), fv[j] - t0, 1 + LL + lat(j));
                chk($sformatf("p0_stream[%0d]", j), s0[j], e[W-1:0]);
                chk($sformatf("p1_stream[%0d]", j), s1[j], e[2*W-1:W]);
            end
        end
    endtask

    task automatic txg(input logic [W-1:0] a, input logic [W-1:0] b);
        txn(a, b, ^a, ^b);
    endtask

    task automatic abort_at(input logic [W-1:0] a, input logic [W-1:0] b, input int off, input logic in_unload);
        @(posedge clk) #1;
        start = 1;
        @(posedge clk) #1;
        start = 0;
        for (int i = 1; i < off; i++) begin
            a_pad = i <= W ? a[i-1] : (i == LL ? ^a : 1'b0);
            b_pad = i <= W ? b[i-1] : (i == LL ? ^b : 1'b0);
            @(posedge clk) #1;
        end
        chk("pre_abort_busy", bz[0], 1);
        chk("pre_abort_valid", pv[0], in_unload);
        #2 rst = 1;
        #1;
        chk("abort_outputs_async", {pp0, pp1, pv, bz, dn, pe}, 0);
        chk("abort_operands_async", {oa[0], ob[0]}, 0);
        @(posedge clk) #1 rst = 0;
        a_pad = 0; b_pad = 0;
    endtask

    initial begin
        rst = 1; start = 0; a_pad = 0; b_pad = 0; rec = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {pp0, pp1, pv, bz, dn, pe}, 0);
        chk("reset_operands", {oa[0], ob[0]}, 0);
        rst = 0;
        txg(16'h1234, 16'h5678);
        txg(16'hFFFF, 16'hFFFF);
        txg(16'h0000, 16'hABCD);
        for (int i = 0; i < 6; i++) txg(16'($urandom), 16'($urandom));
        begin : hold
            logic [W-1:0] a, b;
            logic [2*W-1:0] e;
            int t0, d0;
            a = 16'($urandom); b = 16'($urandom);
            e = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            d0 = LL + 2 + W + 1;
            @(posedge clk) #1;
            rec = 1; t0 = cyc; start = 1;
            for (int c = 1; c <= d0 + 2; c++) begin
                @(posedge clk) #1;
                start = (c != d0 - 8);
                a_pad = c <= W ? a[c-1] : (c == LL ? ^a : 1'b0);
                b_pad = c <= W ? b[c-1] : (c == LL ? ^b : 1'b0);
                if (c == d0 + 1) begin
                    rec = 0;
                    chk("hold_done_count", dcnt[0], 1);
                    chk("hold_done_cycle", dcyc[0] - t0, d0);
                    chk("hold_p0_stream", s0[0], e[W-1:0]);
                    chk("hold_p1_stream", s1[0], e[2*W-1:W]);
                    chk("hold_idle_after_done", bz[0], 0);
                end
                if (c == d0 + 2) chk("hold_reload_after_idle", bz[0], 1);
            end
            start = 0; a_pad = 0; b_pad = 0;
            repeat (80) @(posedge clk);
        end
        abort_at(16'hFFFF, 16'hFFFF, 8, 1'b0);
        txg(16'h0003, 16'h0005);
        abort_at(16'hFFFF, 16'hFFFF, LL + 6, 1'b1);
        txg(16'h0003, 16'h0005);
`ifdef MULT_CTRL_PARITY_EN
        txn(16'h0001, 16'h0003, 1'b0, 1'b0);
        txn(16'h0001, 16'h0003, 1'b1, 1'b0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
